// File: rtl/aq_mem_pkg.sv
// rtl/aq_mem_pkg.sv - shared types and defaults for the main_ram port arbiter
// Purpose: owner encoding for the RAM port and default address/data widths.
package aq_mem_pkg;

  localparam int AQ_AW = 16;
  localparam int AQ_DW = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_LDR  = 2'd2,
    OWN_TAPE = 2'd3
  } owner_t;

endpackage

// File: rtl/aq_sync_fifo.sv
// rtl/aq_sync_fifo.sv - synchronous FIFO buffering loader writes
// Purpose: power-of-2 deep FIFO; a push into a full FIFO is accepted when a pop
//          happens in the same cycle.
// Ports:   i_clk/i_rst_n  clock, async active-low reset
//          i_push/i_wdata push strobe and entry
//          i_pop          pop strobe (ignored while empty)
//          o_rdata        head entry
//          o_full/o_empty/o_count  occupancy
module aq_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [PW:0]      o_count
);

  localparam logic [PW:0] C_FULL = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [PW:0]      r_count;
  logic             w_pop;
  logic             w_push;

  assign w_pop   = i_pop & (r_count != '0);
  // A full FIFO still takes the push when the head leaves in the same cycle.
  assign w_push  = i_push & ((r_count != C_FULL) | w_pop);
  assign o_rdata = r_mem[r_rptr];
  assign o_full  = (r_count == C_FULL);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + (PW+1)'(1);
      else if (w_pop && !w_push) r_count <= r_count - (PW+1)'(1);
    end
  end

endmodule

// File: rtl/aq_mem_arbiter.sv
// rtl/aq_mem_arbiter.sv - main_ram CPU-port arbiter for CPU, loader and tape
// Purpose: per-cycle grant of the single RAM port; CPU has priority on its clock
//          enable, loader/tape alternate otherwise, and a CPU cycle is stolen once
//          loader/tape have lost STARVE_MAX consecutive cycles.
// Ports:   i_clk_sys/i_reset_n      clock, async active-low reset
//          i_cpu_*  / o_cpu_ce      CPU request and gated clock enable
//          i_ldr_*  / o_ldr_wait/o_ldr_ovf   buffered loader writes
//          i_tape_* / o_tape_*      tape read request, ack, returned data
//          o_ram_* / i_ram_rdata    RAM port (read data one cycle after enable)
module aq_mem_arbiter
  import aq_mem_pkg::*;
#(
  parameter int AW         = AQ_AW,
  parameter int DW         = AQ_DW,
  parameter int LDR_DEPTH  = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic          i_clk_sys,
  input  logic          i_reset_n,
  input  logic          i_cpu_ce_in,
  output logic          o_cpu_ce,
  input  logic [AW-1:0] i_cpu_addr,
  input  logic [DW-1:0] i_cpu_din,
  input  logic          i_cpu_we,
  input  logic          i_ldr_wr,
  input  logic [AW-1:0] i_ldr_addr,
  input  logic [DW-1:0] i_ldr_data,
  output logic          o_ldr_wait,
  output logic          o_ldr_ovf,
  input  logic          i_tape_req,
  input  logic [AW-1:0] i_tape_addr,
  output logic          o_tape_ack,
  output logic          o_tape_valid,
  output logic [DW-1:0] o_tape_data,
  output logic          o_ram_en,
  output logic          o_ram_we,
  output logic [AW-1:0] o_ram_addr,
  output logic [DW-1:0] o_ram_wdata,
  input  logic [DW-1:0] i_ram_rdata
);

  localparam int FW = AW + DW;
  localparam int CW = $clog2(LDR_DEPTH) + 1;
  localparam logic [7:0] C_STARVE_MAX = 8'(STARVE_MAX);

  logic [FW-1:0] w_fifo_head;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic [CW-1:0] w_fifo_count;
  logic          w_pop;
  logic          w_ldr_req;
  logic          w_pending;
  logic          w_steal;
  owner_t        w_grant;
  owner_t        r_owner_q;
  logic [7:0]    r_starve_cnt;
  logic          r_rr_tape_last;
  logic [AW-1:0] r_last_addr;
  logic [DW-1:0] r_last_wdata;
  logic [DW-1:0] r_tape_data;
  logic          r_ldr_ovf;

  aq_sync_fifo #(.DEPTH(LDR_DEPTH), .WIDTH(FW)) u_ldr_fifo (
    .i_clk   (i_clk_sys),
    .i_rst_n (i_reset_n),
    .i_push  (i_ldr_wr),
    .i_wdata ({i_ldr_addr, i_ldr_data}),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign w_ldr_req = ~w_fifo_empty;
  assign w_pending = w_ldr_req | i_tape_req;
  assign w_steal   = (r_starve_cnt == C_STARVE_MAX) & i_cpu_ce_in & w_pending;
  // The CPU just sees a missing enable and advances on a later one.
  assign o_cpu_ce  = i_cpu_ce_in & ~w_steal;

  // Owner register: remembers who had the port last cycle (tape read return).
  always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
    if (!i_reset_n) r_owner_q <= OWN_NONE;
    else            r_owner_q <= w_grant;
  end

  // Grant selection.
  always_comb begin
    w_grant = OWN_NONE;
    if (w_steal || !i_cpu_ce_in) begin
      // Tie between loader and tape goes to whichever did not win last time.
      if (w_ldr_req && i_tape_req) w_grant = r_rr_tape_last ? OWN_LDR : OWN_TAPE;
      else if (w_ldr_req)          w_grant = OWN_LDR;
      else if (i_tape_req)         w_grant = OWN_TAPE;
    end else begin
      w_grant = OWN_CPU;
    end
  end

  // RAM port drive for the current owner; address/data hold when idle.
  always_comb begin
    o_ram_en    = 1'b0;
    o_ram_we    = 1'b0;
    o_ram_addr  = r_last_addr;
    o_ram_wdata = r_last_wdata;
    o_tape_ack  = 1'b0;
    w_pop       = 1'b0;
    unique case (w_grant)
      OWN_CPU: begin
        o_ram_en    = 1'b1;
        o_ram_we    = i_cpu_we;
        o_ram_addr  = i_cpu_addr;
        o_ram_wdata = i_cpu_din;
      end
      OWN_LDR: begin
        o_ram_en    = 1'b1;
        o_ram_we    = 1'b1;
        o_ram_addr  = w_fifo_head[FW-1:DW];
        o_ram_wdata = w_fifo_head[DW-1:0];
        w_pop       = 1'b1;
      end
      OWN_TAPE: begin
        o_ram_en    = 1'b1;
        o_ram_addr  = i_tape_addr;
        o_tape_ack  = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_tape_valid = (r_owner_q == OWN_TAPE);
  assign o_tape_data  = o_tape_valid ? i_ram_rdata : r_tape_data;
  assign o_ldr_wait   = (w_fifo_count == CW'(LDR_DEPTH));
  assign o_ldr_ovf    = r_ldr_ovf;

  always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_starve_cnt   <= '0;
      r_rr_tape_last <= 1'b0;
      r_last_addr    <= '0;
      r_last_wdata   <= '0;
      r_tape_data    <= '0;
      r_ldr_ovf      <= 1'b0;
    end else begin
      r_last_addr  <= o_ram_addr;
      r_last_wdata <= o_ram_wdata;
      r_tape_data  <= o_tape_data;
      if (w_grant == OWN_LDR || w_grant == OWN_TAPE || !w_pending) r_starve_cnt <= '0;
      else if (r_starve_cnt != C_STARVE_MAX) r_starve_cnt <= r_starve_cnt + 8'd1;
      if (w_grant == OWN_LDR)       r_rr_tape_last <= 1'b0;
      else if (w_grant == OWN_TAPE) r_rr_tape_last <= 1'b1;
      if (i_ldr_wr && w_fifo_full && !w_pop) r_ldr_ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_aq_mem_arbiter.sv
// tb/tb_aq_mem_arbiter.sv - self-checking bench for aq_mem_arbiter
module tb_aq_mem_arbiter;

  localparam int SMAX  = 8;
  localparam int DEPTH = 4;
  localparam int W_NONE = 0, W_CPU = 1, W_LDR = 2, W_TAPE = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_ce_in, cpu_we, ldr_wr, tape_req;
  logic [15:0] cpu_addr, ldr_addr, tape_addr;
  logic [7:0]  cpu_din, ldr_data;
  logic        o_cpu_ce, o_ldr_wait, o_ldr_ovf, o_tape_ack, o_tape_valid, o_ram_en, o_ram_we;
  logic [7:0]  o_tape_data, o_ram_wdata, ram_rdata;
  logic [15:0] o_ram_addr;
  logic [7:0]  mem [0:65535];
  logic [7:0]  ref_mem [0:255];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  aq_mem_arbiter #(.AW(16), .DW(8), .LDR_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .i_clk_sys(clk), .i_reset_n(rst_n), .i_cpu_ce_in(cpu_ce_in), .o_cpu_ce(o_cpu_ce),
    .i_cpu_addr(cpu_addr), .i_cpu_din(cpu_din), .i_cpu_we(cpu_we),
    .i_ldr_wr(ldr_wr), .i_ldr_addr(ldr_addr), .i_ldr_data(ldr_data),
    .o_ldr_wait(o_ldr_wait), .o_ldr_ovf(o_ldr_ovf),
    .i_tape_req(tape_req), .i_tape_addr(tape_addr), .o_tape_ack(o_tape_ack),
    .o_tape_valid(o_tape_valid), .o_tape_data(o_tape_data),
    .o_ram_en(o_ram_en), .o_ram_we(o_ram_we), .o_ram_addr(o_ram_addr),
    .o_ram_wdata(o_ram_wdata), .i_ram_rdata(ram_rdata)
  );

  // Behavioural RAM with one cycle read latency.
  always @(posedge clk) begin
    if (o_ram_en) begin
      if (o_ram_we) mem[o_ram_addr] <= o_ram_wdata;
      ram_rdata <= mem[o_ram_addr];
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    cpu_ce_in = 0; cpu_we = 0; cpu_addr = '0; cpu_din = '0;
    ldr_wr = 0; ldr_addr = '0; ldr_data = '0; tape_req = 0; tape_addr = '0;
  endtask

  task automatic idle(input int n);
    drive_idle();
    repeat (n) next();
  endtask

  task automatic do_reset();
    drive_idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({o_cpu_ce, o_ram_en, o_ram_we, o_tape_ack, o_tape_valid, o_ldr_wait, o_ldr_ovf} !== 7'b0) begin
      n_errors++; $display("FAIL reset_flags got %b exp 0", {o_cpu_ce, o_ram_en, o_ram_we, o_tape_ack, o_tape_valid, o_ldr_wait, o_ldr_ovf});
    end
    n_checks++;
    if ({o_ram_addr, o_ram_wdata, o_tape_data} !== 32'h0) begin
      n_errors++; $display("FAIL reset_buses got %h exp 0", {o_ram_addr, o_ram_wdata, o_tape_data});
    end
    @(posedge clk); #1 rst_n = 1'b1;
    next();
    @(negedge clk);
    n_checks++;
    if ({o_ram_en, o_ldr_wait, o_ldr_ovf, o_tape_valid} !== 4'b0) begin
      n_errors++; $display("FAIL post_reset_idle got %b exp 0", {o_ram_en, o_ldr_wait, o_ldr_ovf, o_tape_valid});
    end
    next();
  endtask

  task automatic test_cpu_write();
    idle(2);
    for (int c = 0; c < 48; c++) begin
      cpu_ce_in = (c % 16 == 15); cpu_addr = 16'h3900; cpu_din = 8'h3A; cpu_we = (c < 32);
      @(negedge clk);
      n_checks++;
      if (o_cpu_ce !== cpu_ce_in) begin
        n_errors++; $display("FAIL cpu_ce c=%0d got %b exp %b", c, o_cpu_ce, cpu_ce_in);
      end
      n_checks++;
      if (o_ram_we !== (cpu_ce_in & cpu_we)) begin
        n_errors++; $display("FAIL cpu_ram_we c=%0d got %b exp %b", c, o_ram_we, cpu_ce_in & cpu_we);
      end
      next();
    end
    drive_idle();
    @(negedge clk);
    n_checks++;
    if (ram_rdata !== 8'h3A) begin
      n_errors++; $display("FAIL cpu_readback got %h exp 3a", ram_rdata);
    end
    next();
  endtask

  task automatic test_ldr_burst();
    int sent = 0, wr_seen = 0;
    idle(2);
    cpu_ce_in = 1;
    for (int c = 0; c < 60 && wr_seen < 5; c++) begin
      ldr_wr = (sent < 5) && !o_ldr_wait;
      ldr_addr = 16'h2000 + 16'(sent); ldr_data = 8'hA0 + 8'(sent);
      @(negedge clk);
      if (c <= 4) begin
        n_checks++;
        if (o_ldr_wait !== (c == 4)) begin
          n_errors++; $display("FAIL burst_wait c=%0d got %b exp %b", c, o_ldr_wait, c == 4);
        end
      end
      if (o_ram_en && o_ram_we) begin
        n_checks++;
        if (c != 9 * (wr_seen + 1) || o_cpu_ce !== 1'b0) begin
          n_errors++; $display("FAIL burst_write_cycle got c=%0d ce=%b exp c=%0d ce=0", c, o_cpu_ce, 9 * (wr_seen + 1));
        end
        n_checks++;
        if (o_ram_addr !== 16'h2000 + 16'(wr_seen) || o_ram_wdata !== 8'hA0 + 8'(wr_seen)) begin
          n_errors++; $display("FAIL burst_write_data got %h/%h exp %h/%h", o_ram_addr, o_ram_wdata, 16'h2000 + 16'(wr_seen), 8'hA0 + 8'(wr_seen));
        end
        wr_seen++;
      end
      if (ldr_wr) sent++;
      next();
    end
    drive_idle();
    n_checks++;
    if (wr_seen != 5) begin
      n_errors++; $display("FAIL burst_count got %0d exp 5", wr_seen);
    end
    n_checks++;
    if (o_ldr_ovf !== 1'b0) begin
      n_errors++; $display("FAIL burst_ovf got %b exp 0", o_ldr_ovf);
    end
  endtask

  task automatic test_ldr_overflow();
    int n = 0;
    idle(2);
    cpu_ce_in = 1;
    for (int c = 0; c < 5; c++) begin
      ldr_wr = 1; ldr_addr = 16'h2100 + 16'(c); ldr_data = 8'hB0 + 8'(c);
      @(negedge clk);
      if (c == 4) begin
        n_checks++;
        if (o_ldr_ovf !== 1'b0) begin
          n_errors++; $display("FAIL ovf_early got %b exp 0", o_ldr_ovf);
        end
      end
      next();
    end
    ldr_wr = 0;
    for (int d = 0; d < 50; d++) begin
      @(negedge clk);
      if (d == 0) begin
        n_checks++;
        if (o_ldr_ovf !== 1'b1) begin
          n_errors++; $display("FAIL ovf_set got %b exp 1", o_ldr_ovf);
        end
      end
      if (o_ram_en && o_ram_we) begin
        n_checks++;
        if (o_ram_addr !== 16'h2100 + 16'(n) || o_ram_wdata !== 8'hB0 + 8'(n)) begin
          n_errors++; $display("FAIL ovf_drain_entry got %h/%h exp %h/%h", o_ram_addr, o_ram_wdata, 16'h2100 + 16'(n), 8'hB0 + 8'(n));
        end
        n++;
      end
      next();
    end
    n_checks++;
    if (n != 4 || o_ldr_ovf !== 1'b1) begin
      n_errors++; $display("FAIL ovf_dropped got writes=%0d ovf=%b exp writes=4 ovf=1", n, o_ldr_ovf);
    end
    do_reset();
    @(negedge clk);
    n_checks++;
    if (o_ldr_ovf !== 1'b0) begin
      n_errors++; $display("FAIL ovf_reset got %b exp 0", o_ldr_ovf);
    end
    next();
  endtask

  task automatic test_tape_alternate();
    int tn = 0, ln = 0, last_w = W_NONE, w;
    logic       prev_ack = 0;
    logic [7:0] prev_exp = '0;
    idle(2);
    mem[16'h0010] = 8'h55;
    mem[16'h0011] = 8'h66;
    for (int c = 0; c < 12; c++) begin
      ldr_wr = (c < 2); ldr_addr = 16'h3000 + 16'(c); ldr_data = 8'hC0 + 8'(c);
      tape_req = (c >= 1) && (tn < 2);
      tape_addr = (tn == 0) ? 16'h0010 : 16'h0011;
      @(negedge clk);
      n_checks++;
      if (o_tape_valid !== prev_ack) begin
        n_errors++; $display("FAIL alt_valid c=%0d got %b exp %b", c, o_tape_valid, prev_ack);
      end
      if (prev_ack) begin
        n_checks++;
        if (o_tape_data !== prev_exp) begin
          n_errors++; $display("FAIL alt_tape_data got %h exp %h", o_tape_data, prev_exp);
        end
      end
      w = o_tape_ack ? W_TAPE : ((o_ram_en && o_ram_we) ? W_LDR : W_NONE);
      if (o_tape_ack) begin
        n_checks++;
        if (o_ram_we !== 1'b0 || o_ram_addr !== tape_addr) begin
          n_errors++; $display("FAIL alt_tape_port got we=%b addr=%h exp we=0 addr=%h", o_ram_we, o_ram_addr, tape_addr);
        end
      end
      if (c >= 1 && c <= 4) begin
        n_checks++;
        if (w == W_NONE || w == last_w) begin
          n_errors++; $display("FAIL alt_grant c=%0d got %0d prev %0d exp alternating", c, w, last_w);
        end
      end
      last_w = w;
      prev_ack = o_tape_ack;
      prev_exp = (tn == 0) ? 8'h55 : 8'h66;
      if (o_tape_ack) tn++;
      if (w == W_LDR) ln++;
      next();
    end
    drive_idle();
    n_checks++;
    if (tn != 2 || ln != 2) begin
      n_errors++; $display("FAIL alt_counts got tape=%0d ldr=%0d exp 2/2", tn, ln);
    end
  endtask

  task automatic test_steal_rate();
    int stolen = 0;
    idle(2);
    cpu_ce_in = 1; tape_req = 1; tape_addr = 16'h0020;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if (o_cpu_ce === 1'b0) stolen++;
      n_checks++;
      if (o_cpu_ce !== (c % 9 != 8) || o_tape_ack !== (c % 9 == 8)) begin
        n_errors++; $display("FAIL steal c=%0d got ce=%b ack=%b exp ce=%b", c, o_cpu_ce, o_tape_ack, c % 9 != 8);
      end
      next();
    end
    drive_idle();
    n_checks++;
    if (stolen != 5) begin
      n_errors++; $display("FAIL steal_count got %0d exp 5", stolen);
    end
  endtask

  task automatic test_reset_mid_drain();
    int bad = 0;
    idle(2);
    cpu_ce_in = 1;
    for (int c = 0; c < 3; c++) begin
      ldr_wr = 1; ldr_addr = 16'h3100 + 16'(c); ldr_data = 8'hD0 + 8'(c);
      next();
    end
    ldr_wr = 0; cpu_ce_in = 0;
    @(negedge clk);
    n_checks++;
    if (!(o_ram_en && o_ram_we) || o_ram_addr !== 16'h3100) begin
      n_errors++; $display("FAIL drain_first got en=%b we=%b addr=%h exp 1/1/3100", o_ram_en, o_ram_we, o_ram_addr);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (o_ram_en !== 1'b0 || o_ldr_wait !== 1'b0) begin
      n_errors++; $display("FAIL drain_in_reset got en=%b wait=%b exp 0/0", o_ram_en, o_ldr_wait);
    end
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (o_ram_en !== 1'b0) bad++;
      next();
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++; $display("FAIL drain_after_reset got %0d ram cycles exp 0", bad);
    end
    tape_req = 1; tape_addr = 16'h0010;
    @(negedge clk);
    n_checks++;
    if (o_tape_ack !== 1'b1) begin
      n_errors++; $display("FAIL inflight_ack got %b exp 1", o_tape_ack);
    end
    rst_n = 1'b0; tape_req = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (o_tape_valid !== 1'b0) bad++;
      next();
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++; $display("FAIL inflight_valid got %0d pulses exp 0", bad);
    end
  endtask

  task automatic test_random();
    logic [23:0] q[$];
    int          starve = 0, win;
    logic        last_tape = 0, prev_tape = 0, ovf = 0, got_ack = 0, pl, pt, steal;
    logic [7:0]  prev_data = '0, exp_wdata;
    logic [15:0] last_addr = 16'h8000, exp_addr;
    logic        exp_en, exp_we;
    do_reset();
    // One lone loader write so the tie-break history starts from a known winner.
    ldr_wr = 1; ldr_addr = 16'h8000; ldr_data = 8'h00;
    next();
    drive_idle();
    next(); next();
    for (int i = 0; i < 256; i++) begin
      mem[16'h8000 + 16'(i)] = 8'($urandom);
      ref_mem[i] = mem[16'h8000 + 16'(i)];
    end
    for (int c = 0; c < 500; c++) begin
      cpu_ce_in = ($urandom % 3) == 0;
      cpu_we = 1'($urandom % 2);
      cpu_addr = 16'h8000 | 16'($urandom % 256); cpu_din = 8'($urandom);
      ldr_wr = (($urandom % 2) == 1) && ((($urandom % 4) == 0) || !o_ldr_wait);
      ldr_addr = 16'h8000 | 16'($urandom % 256); ldr_data = 8'($urandom);
      if (tape_req && got_ack) begin
        tape_req = 1'($urandom % 2); tape_addr = 16'h8000 | 16'($urandom % 256);
      end else if (!tape_req) begin
        tape_req = ($urandom % 3) == 0; tape_addr = 16'h8000 | 16'($urandom % 256);
      end
      @(negedge clk);
      pl = (q.size() > 0);
      pt = tape_req;
      steal = (starve == SMAX) && cpu_ce_in && (pl || pt);
      win = W_NONE;
      if (steal || !cpu_ce_in) begin
        if (pl && pt) win = last_tape ? W_LDR : W_TAPE;
        else if (pl)  win = W_LDR;
        else if (pt)  win = W_TAPE;
      end else win = W_CPU;
      exp_en = (win != W_NONE); exp_we = 0; exp_addr = last_addr; exp_wdata = '0;
      if (win == W_CPU)  begin exp_we = cpu_we; exp_addr = cpu_addr; exp_wdata = cpu_din; end
      if (win == W_LDR)  begin exp_we = 1; exp_addr = q[0][23:8]; exp_wdata = q[0][7:0]; end
      if (win == W_TAPE) exp_addr = tape_addr;
      n_checks++;
      if (o_cpu_ce !== (cpu_ce_in && !steal)) begin
        n_errors++; $display("FAIL rnd_cpu_ce c=%0d got %b exp %b", c, o_cpu_ce, cpu_ce_in && !steal);
      end
      n_checks++;
      if (o_ram_en !== exp_en || o_ram_we !== exp_we || o_ram_addr !== exp_addr) begin
        n_errors++; $display("FAIL rnd_port c=%0d got %b%b %h exp %b%b %h", c, o_ram_en, o_ram_we, o_ram_addr, exp_en, exp_we, exp_addr);
      end
      if (exp_we) begin
        n_checks++;
        if (o_ram_wdata !== exp_wdata) begin
          n_errors++; $display("FAIL rnd_wdata c=%0d got %h exp %h", c, o_ram_wdata, exp_wdata);
        end
      end
      n_checks++;
      if (o_tape_ack !== (win == W_TAPE) || o_tape_valid !== prev_tape) begin
        n_errors++; $display("FAIL rnd_tape c=%0d got ack=%b valid=%b exp %b/%b", c, o_tape_ack, o_tape_valid, win == W_TAPE, prev_tape);
      end
      if (prev_tape) begin
        n_checks++;
        if (o_tape_data !== prev_data) begin
          n_errors++; $display("FAIL rnd_tape_data c=%0d got %h exp %h", c, o_tape_data, prev_data);
        end
      end
      n_checks++;
      if (o_ldr_wait !== (q.size() == DEPTH) || o_ldr_ovf !== ovf) begin
        n_errors++; $display("FAIL rnd_ldr c=%0d got wait=%b ovf=%b exp %b/%b", c, o_ldr_wait, o_ldr_ovf, q.size() == DEPTH, ovf);
      end
      if (win == W_TAPE) prev_data = ref_mem[tape_addr[7:0]];
      if (exp_we) ref_mem[exp_addr[7:0]] = exp_wdata;
      if (win == W_LDR) void'(q.pop_front());
      if (ldr_wr) begin
        if (q.size() < DEPTH) q.push_back({ldr_addr, ldr_data});
        else ovf = 1;
      end
      if (win == W_LDR || win == W_TAPE) starve = 0;
      else if (pl || pt) starve = (starve < SMAX) ? starve + 1 : SMAX;
      else starve = 0;
      if (win == W_LDR)  last_tape = 0;
      if (win == W_TAPE) last_tape = 1;
      prev_tape = (win == W_TAPE);
      if (exp_en) last_addr = exp_addr;
      got_ack = o_tape_ack;
      next();
    end
    drive_idle();
  endtask

  initial begin
    drive_idle();
    rst_n = 1'b0;
    ram_rdata = '0;
    test_reset();
    test_cpu_write();
    test_ldr_burst();
    test_ldr_overflow();
    test_tape_alternate();
    test_steal_rate();
    test_reset_mid_drain();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
